// File: rtl/dual_counter_if.sv
// Pin bundle for dual_counter: control/load inputs towards the counter,
// registered counter, history and flag outputs back from it.
interface dual_counter_if #(
   parameter int W = 3
);
   logic         a;
   logic         b;
   logic         clr;
   logic         ld;
   logic [W-1:0] din;
   logic         c;
   logic [W-1:0] s1;
   logic [W-1:0] s2;
   logic         ovf;
   logic         unf;

   modport master (
      output a, b, clr, ld, din,
      input  c, s1, s2, ovf, unf
   );

   modport slave (
      input  a, b, clr, ld, din,
      output c, s1, s2, ovf, unf
   );
endinterface

// File: rtl/dual_counter.sv
// Up/down counter with clear/load, sticky overflow/underflow flags, plus a
// registered a&b strobe and a W-deep shift history of that strobe.
module dual_counter #(
   parameter int           W    = 3,
   parameter int           WRAP = 1,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic          clk,
   input  logic          rstn,
   dual_counter_if.slave bus
);
   localparam logic [W-1:0] MAX = '1;
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic         c_q,   c_d;
   logic [W-1:0] s1_q,  s1_d;
   logic [W-1:0] s2_q,  s2_d;
   logic         ovf_q, ovf_d;
   logic         unf_q, unf_d;

   // NOTE: every variable is given a default first so no branch leaves it
   // unassigned; a missing default in always_comb infers a latch.
   always_comb begin
      c_d   = bus.a & bus.b;
      s2_d  = {s2_q[W-2:0], c_d};
      s1_d  = s1_q;
      ovf_d = ovf_q;
      unf_d = unf_q;

      if (bus.clr) begin
         s1_d  = INIT;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else if (bus.ld) begin
         s1_d = bus.din;
      end else if (bus.a) begin
         if (bus.b) begin
            if (s1_q == MAX) begin
               ovf_d = 1'b1;
               s1_d  = (WRAP != 0) ? '0 : MAX;
            end else begin
               s1_d = s1_q + ONE;
            end
         end else begin
            if (s1_q == '0) begin
               unf_d = 1'b1;
               s1_d  = (WRAP != 0) ? MAX : '0;
            end else begin
               s1_d = s1_q - ONE;
            end
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge value of its _d input regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         c_q   <= 1'b0;
         s1_q  <= INIT;
         s2_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         c_q   <= c_d;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.c   = c_q;
   assign bus.s1  = s1_q;
   assign bus.s2  = s2_q;
   assign bus.ovf = ovf_q;
   assign bus.unf = unf_q;
endmodule

// File: tb/tb_dual_counter.sv
// Directed bench for dual_counter: a wrapping and a saturating instance run the
// same stimulus, checked against a scoreboard model and scenario constants.
module tb_dual_counter;
   localparam int W = 3;

   typedef struct packed {
      logic       c;
      logic [2:0] s2;
      logic [2:0] s1_w;
      logic       ovf_w;
      logic       unf_w;
      logic [2:0] s1_s;
      logic       ovf_s;
      logic       unf_s;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b1;

   dual_counter_if #(.W(W)) if_w ();
   dual_counter_if #(.W(W)) if_s ();

   dual_counter #(.W(W), .WRAP(1), .INIT(3'd0)) u_wrap (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if_w.slave)
   );

   dual_counter #(.W(W), .WRAP(0), .INIT(3'd0)) u_sat (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if_s.slave)
   );

   always #5 clk = ~clk;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   // Reference model state; index 0 = wrapping instance, 1 = saturating.
   int m_c;
   int m_s2;
   int m_s1  [2];
   int m_ovf [2];
   int m_unf [2];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_c  = 0;
      m_s2 = 0;
      for (int k = 0; k < 2; k++) begin
         m_s1[k]  = 0;
         m_ovf[k] = 0;
         m_unf[k] = 0;
      end
   endtask

   task automatic model_step(input logic a, input logic b, input logic clr,
                             input logic ld, input logic [2:0] din);
      exp_t e;
      int   nxt;
      m_c  = (a && b) ? 1 : 0;
      m_s2 = ((m_s2 * 2) + m_c) % 8;
      for (int k = 0; k < 2; k++) begin
         if (clr) begin
            m_s1[k]  = 0;
            m_ovf[k] = 0;
            m_unf[k] = 0;
         end else if (ld) begin
            m_s1[k] = int'(din);
         end else if (a) begin
            nxt = m_s1[k] + (b ? 1 : -1);
            if (nxt > 7) begin
               m_ovf[k] = 1;
               m_s1[k]  = (k == 0) ? 0 : 7;
            end else if (nxt < 0) begin
               m_unf[k] = 1;
               m_s1[k]  = (k == 0) ? 7 : 0;
            end else begin
               m_s1[k] = nxt;
            end
         end
      end
      e.c     = (m_c != 0);
      e.s2    = 3'(m_s2);
      e.s1_w  = 3'(m_s1[0]);
      e.ovf_w = (m_ovf[0] != 0);
      e.unf_w = (m_unf[0] != 0);
      e.s1_s  = 3'(m_s1[1]);
      e.ovf_s = (m_ovf[1] != 0);
      e.unf_s = (m_unf[1] != 0);
      sb_q.push_back(e);
   endtask

   task automatic compare_sb();
      exp_t e;
      n_assert++;
      assert (sb_q.size() != 0) else begin
         n_fail++;
         $error("FAIL sb_empty: observed 0 entries expected 1");
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("sb_c_wrap",   16'(if_w.c),   16'(e.c));
         check("sb_c_sat",    16'(if_s.c),   16'(e.c));
         check("sb_s2_wrap",  16'(if_w.s2),  16'(e.s2));
         check("sb_s2_sat",   16'(if_s.s2),  16'(e.s2));
         check("sb_s1_wrap",  16'(if_w.s1),  16'(e.s1_w));
         check("sb_ovf_wrap", 16'(if_w.ovf), 16'(e.ovf_w));
         check("sb_unf_wrap", 16'(if_w.unf), 16'(e.unf_w));
         check("sb_s1_sat",   16'(if_s.s1),  16'(e.s1_s));
         check("sb_ovf_sat",  16'(if_s.ovf), 16'(e.ovf_s));
         check("sb_unf_sat",  16'(if_s.unf), 16'(e.unf_s));
      end
   endtask

   // Drive at edge+1, let one rising edge pass, compare at the next edge+1.
   task automatic step(input logic a, input logic b, input logic clr,
                       input logic ld, input logic [2:0] din);
      if_w.a = a;  if_w.b = b;  if_w.clr = clr;  if_w.ld = ld;  if_w.din = din;
      if_s.a = a;  if_s.b = b;  if_s.clr = clr;  if_s.ld = ld;  if_s.din = din;
      model_step(a, b, clr, ld, din);
      @(posedge clk);
      #1;
      compare_sb();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_c"},   16'(if_w.c),   16'd0);
      check({tag, "_s1"},  16'(if_w.s1),  16'd0);
      check({tag, "_s2"},  16'(if_w.s2),  16'd0);
      check({tag, "_ovf"}, 16'(if_w.ovf), 16'd0);
      check({tag, "_unf"}, 16'(if_w.unf), 16'd0);
      check({tag, "_s1_sat"}, 16'(if_s.s1), 16'd0);
      check({tag, "_s2_sat"}, 16'(if_s.s2), 16'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      if_w.a = 0;  if_w.b = 0;  if_w.clr = 0;  if_w.ld = 0;  if_w.din = '0;
      if_s.a = 0;  if_s.b = 0;  if_s.clr = 0;  if_s.ld = 0;  if_s.din = '0;

      // Asynchronous reset: outputs must settle before any clock edge.
      #2 rstn = 1'b0;
      #1 check_reset("rst_async");
      model_reset();
      @(posedge clk);
      #1 rstn = 1'b1;

      // Up-count with wrap: s1 steps 1..7,0; s2 fills 001,011,111.
      for (int i = 1; i <= 8; i++) begin
         step(1, 1, 0, 0, 3'd0);
         check("up_s1_wrap", 16'(if_w.s1), 16'(i % 8));
         if (i <= 3) check("up_s2_fill", 16'(if_w.s2), 16'((1 << i) - 1));
         if (i >= 7) check("up_ovf_wrap", 16'(if_w.ovf), 16'(i == 8));
      end
      check("up_c", 16'(if_w.c), 16'd1);
      step(0, 0, 1, 0, 3'd0);
      check("clr_ovf", 16'(if_w.ovf), 16'd0);

      // Saturating load then up-count: 6,7,7,7 with ovf on the first attempt at 7.
      step(0, 0, 0, 1, 3'd6);
      check("sat_ld6", 16'(if_s.s1), 16'd6);
      for (int j = 0; j < 3; j++) begin
         step(1, 1, 0, 0, 3'd0);
         check("sat_s1", 16'(if_s.s1), 16'd7);
         check("sat_ovf", 16'(if_s.ovf), 16'(j >= 1));
      end
      // Load leaves the sticky flag alone and beats a coincident count.
      step(1, 1, 0, 1, 3'd2);
      check("ld_keep_s1", 16'(if_s.s1), 16'd2);
      check("ld_keep_ovf", 16'(if_s.ovf), 16'd1);

      // Down-count at 0 from clear: wrap gives 7, saturate holds 0, both unf.
      step(0, 0, 1, 0, 3'd0);
      step(1, 0, 0, 0, 3'd0);
      check("dn_s1_wrap", 16'(if_w.s1), 16'd7);
      check("dn_unf_wrap", 16'(if_w.unf), 16'd1);
      check("dn_s1_sat", 16'(if_s.s1), 16'd0);
      check("dn_unf_sat", 16'(if_s.unf), 16'd1);
      // Clear with an up-count at 7: no flag, c and s2 still follow a&b.
      step(1, 1, 1, 0, 3'd0);
      check("clr_bnd_s1", 16'(if_w.s1), 16'd0);
      check("clr_bnd_ovf", 16'(if_w.ovf), 16'd0);
      check("clr_bnd_unf", 16'(if_w.unf), 16'd0);
      check("clr_c", 16'(if_w.c), 16'd1);
      check("clr_s2", 16'(if_w.s2), 16'b001);

      // Priority: clr over ld over count; then ld over count.
      step(1, 1, 1, 1, 3'd5);
      check("prio_clr", 16'(if_w.s1), 16'd0);
      step(1, 1, 0, 1, 3'd5);
      check("prio_ld", 16'(if_w.s1), 16'd5);

      // Strobe sequence a,b = 11,01,11.
      step(1, 1, 0, 0, 3'd0);
      check("seq_c1", 16'(if_w.c), 16'd1);
      step(0, 1, 0, 0, 3'd0);
      check("seq_c0", 16'(if_w.c), 16'd0);
      step(1, 1, 0, 0, 3'd0);
      check("seq_c1b", 16'(if_w.c), 16'd1);
      check("seq_s2", 16'(if_w.s2), 16'b101);

      // Full-width load value and saturating underflow.
      step(0, 0, 0, 1, 3'd7);
      check("ld_full", 16'(if_s.s1), 16'd7);
      step(1, 1, 0, 0, 3'd0);
      step(0, 0, 0, 1, 3'd1);
      step(1, 0, 0, 0, 3'd0);
      step(1, 0, 0, 0, 3'd0);
      check("sat_dn_hold", 16'(if_s.s1), 16'd0);

      // Mid-cycle reset with s1=4, ovf=1; reset held across an edge.
      step(0, 0, 1, 0, 3'd0);
      for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 3'd0);
      check("pre_rst_s1", 16'(if_w.s1), 16'd4);
      check("pre_rst_ovf", 16'(if_w.ovf), 16'd1);
      #3 rstn = 1'b0;
      #1 check_reset("rst_mid");
      model_reset();
      @(posedge clk);
      #1 check("rst_hold_s1", 16'(if_w.s1), 16'd0);
      rstn = 1'b1;
      step(1, 1, 0, 0, 3'd0);
      check("resume_s1", 16'(if_w.s1), 16'd1);
      check("resume_s1_sat", 16'(if_s.s1), 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
